// File: rtl/buzz_seq.sv
// buzz_seq: buzzer sequencer.
//   Generates an internal square-wave tone (half-period TONE_DIV clocks) and
//   gates it with an ON/OFF cadence: slow, fast or continuous. Runs a
//   programmable number of bursts (0 = until stopped) and can be aborted.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   start      single-cycle request to begin a sequence (ignored while busy)
//   ring[1:0]  mode sampled with start: 00 none, 01 slow, 10 fast, 11 continuous
//   bursts     number of ON/OFF bursts sampled with start, 0 = run until stop
//   stop       abort request, returns to IDLE without a done pulse
//   beep_r     registered buzzer drive
//   busy       high while a sequence runs (ON or OFF)
//   done       one-cycle pulse on normal completion
//   burst_cnt  completed bursts in the current or last sequence (saturating)
module buzz_seq #(
  parameter int DIV_W    = 16,
  parameter int CNT_W    = 8,
  parameter int TONE_DIV = 4,
  parameter int ON_SLOW  = 32,
  parameter int OFF_SLOW = 32,
  parameter int ON_FAST  = 8,
  parameter int OFF_FAST = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       ring,
  input  logic [CNT_W-1:0] bursts,
  input  logic             stop,
  output logic             beep_r,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] burst_cnt
);

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

  localparam logic [DIV_W-1:0] TONE_LAST     = DIV_W'(TONE_DIV - 1);
  localparam logic [DIV_W-1:0] ON_SLOW_LAST  = DIV_W'(ON_SLOW - 1);
  localparam logic [DIV_W-1:0] OFF_SLOW_LAST = DIV_W'(OFF_SLOW - 1);
  localparam logic [DIV_W-1:0] ON_FAST_LAST  = DIV_W'(ON_FAST - 1);
  localparam logic [DIV_W-1:0] OFF_FAST_LAST = DIV_W'(OFF_FAST - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] tone_cnt_q, tone_cnt_d;
  logic [DIV_W-1:0] phase_cnt_q, phase_cnt_d;
  logic             beep_q, beep_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [1:0]       ring_q, ring_d;
  logic [CNT_W-1:0] bursts_q, bursts_d;

  logic [DIV_W-1:0] on_last, off_last;
  logic [CNT_W-1:0] burst_cnt_inc;

  // Phase lengths follow the latched mode; continuous mode never leaves ON,
  // so its entries here are don't-care.
  always_comb begin
    on_last  = (ring_q == 2'b01) ? ON_SLOW_LAST  : ON_FAST_LAST;
    off_last = (ring_q == 2'b01) ? OFF_SLOW_LAST : OFF_FAST_LAST;
  end

  // Saturate rather than wrap so a long bursts=0 run never reads back as 0.
  assign burst_cnt_inc = (burst_cnt_q == {CNT_W{1'b1}}) ? burst_cnt_q
                                                        : burst_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    tone_cnt_d  = tone_cnt_q;
    phase_cnt_d = phase_cnt_q;
    beep_d      = beep_q;
    burst_cnt_d = burst_cnt_q;
    ring_d      = ring_q;
    bursts_d    = bursts_q;

    case (state_q)
      IDLE: begin
        // stop in the same cycle suppresses the start.
        if (start && !stop && (ring != 2'b00)) begin
          ring_d      = ring;
          bursts_d    = bursts;
          burst_cnt_d = '0;
          tone_cnt_d  = '0;
          phase_cnt_d = '0;
          beep_d      = 1'b0;
          state_d     = ON;
        end
      end

      ON: begin
        if (stop) begin
          state_d     = IDLE;
          beep_d      = 1'b0;
          tone_cnt_d  = '0;
          phase_cnt_d = '0;
        end else begin
          if (tone_cnt_q == TONE_LAST) begin
            tone_cnt_d = '0;
            beep_d     = ~beep_q;
          end else begin
            tone_cnt_d = tone_cnt_q + DIV_W'(1);
          end

          if (ring_q == 2'b11) begin
            phase_cnt_d = '0;
          end else if (phase_cnt_q == on_last) begin
            // Leaving ON overrides any toggle due on this edge.
            state_d     = OFF;
            phase_cnt_d = '0;
            tone_cnt_d  = '0;
            beep_d      = 1'b0;
          end else begin
            phase_cnt_d = phase_cnt_q + DIV_W'(1);
          end
        end
      end

      OFF: begin
        beep_d = 1'b0;
        if (stop) begin
          state_d     = IDLE;
          tone_cnt_d  = '0;
          phase_cnt_d = '0;
        end else if (phase_cnt_q == off_last) begin
          phase_cnt_d = '0;
          tone_cnt_d  = '0;
          burst_cnt_d = burst_cnt_inc;
          if ((bursts_q != '0) && (burst_cnt_inc == bursts_q)) begin
            state_d = DONE;
          end else begin
            state_d = ON;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + DIV_W'(1);
        end
      end

      DONE: begin
        beep_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        beep_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tone_cnt_q  <= '0;
      phase_cnt_q <= '0;
      beep_q      <= 1'b0;
      burst_cnt_q <= '0;
      ring_q      <= 2'b00;
      bursts_q    <= '0;
    end else begin
      state_q     <= state_d;
      tone_cnt_q  <= tone_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      beep_q      <= beep_d;
      burst_cnt_q <= burst_cnt_d;
      ring_q      <= ring_d;
      bursts_q    <= bursts_d;
    end
  end

  assign beep_r    = beep_q;
  assign busy      = (state_q == ON) || (state_q == OFF);
  assign done      = (state_q == DONE);
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_buzz_seq.sv
module tb_buzz_seq;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       ring;
  logic [CNT_W-1:0] bursts;
  logic             stop;
  logic             beep_r;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] burst_cnt;

  always #5 clk = ~clk;

  buzz_seq #(
    .DIV_W(16), .CNT_W(CNT_W), .TONE_DIV(4),
    .ON_SLOW(32), .OFF_SLOW(32), .ON_FAST(8), .OFF_FAST(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ring(ring), .bursts(bursts),
    .stop(stop), .beep_r(beep_r), .busy(busy), .done(done), .burst_cnt(burst_cnt)
  );

  typedef struct {
    logic       start;
    logic [1:0] ring;
    logic [7:0] bursts;
    logic       stop;
    logic       e_beep;
    logic       e_busy;
    logic       e_done;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int NVEC = 37;
  vec_t tbl [NVEC];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic eb, input logic ebz,
                       input logic ed, input logic [7:0] ec);
    n_vec++;
    if (beep_r !== eb || busy !== ebz || done !== ed || burst_cnt !== ec) begin
      n_fail++;
      $display("FAIL %s: got beep=%b busy=%b done=%b cnt=%0d, want beep=%b busy=%b done=%b cnt=%0d",
               nm, beep_r, busy, done, burst_cnt, eb, ebz, ed, ec);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] r, input logic [7:0] b, input logic p);
    start  = s;
    ring   = r;
    bursts = b;
    stop   = p;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fast mode, bursts=2: each burst is 8 ON + 8 OFF cycles; within ON the
    // tone is low for 4 cycles then high for 4. Observation c is taken one
    // step after the edge that applied vector c.
    for (int c = 0; c < 34; c++) begin
      tbl[c].start  = (c == 0) || (c == 5);
      tbl[c].ring   = (c == 0) ? 2'b10 : ((c == 5) ? 2'b01 : 2'b00);
      tbl[c].bursts = (c == 0) ? 8'd2  : ((c == 5) ? 8'd1  : 8'd0);
      tbl[c].stop   = 1'b0;
      if (c < 32) begin
        tbl[c].e_beep = ((c % 16) >= 4) && ((c % 16) < 8);
        tbl[c].e_busy = 1'b1;
        tbl[c].e_done = 1'b0;
        tbl[c].e_cnt  = 8'(c / 16);
      end else begin
        tbl[c].e_beep = 1'b0;
        tbl[c].e_busy = 1'b0;
        tbl[c].e_done = (c == 32);
        tbl[c].e_cnt  = 8'd2;
      end
    end
    // start with ring=00 is ignored and does not clear burst_cnt.
    tbl[34] = '{start: 1'b1, ring: 2'b00, bursts: 8'd3, stop: 1'b0,
                e_beep: 1'b0, e_busy: 1'b0, e_done: 1'b0, e_cnt: 8'd2};
    // start together with stop in IDLE is ignored.
    tbl[35] = '{start: 1'b1, ring: 2'b10, bursts: 8'd1, stop: 1'b1,
                e_beep: 1'b0, e_busy: 1'b0, e_done: 1'b0, e_cnt: 8'd2};
    // stop alone in IDLE has no effect.
    tbl[36] = '{start: 1'b0, ring: 2'b00, bursts: 8'd0, stop: 1'b1,
                e_beep: 1'b0, e_busy: 1'b0, e_done: 1'b0, e_cnt: 8'd2};

    drive(1'b0, 2'b00, 8'd0, 1'b0);
    rst_n = 1'b0;
    #12;
    check("reset_state", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check("idle_after_reset", 1'b0, 1'b0, 1'b0, 8'd0);

    // Table: fast bursts=2, ignored start while busy, idle corner cases.
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].start, tbl[i].ring, tbl[i].bursts, tbl[i].stop);
      tick;
      check($sformatf("fast2_vec%0d", i), tbl[i].e_beep, tbl[i].e_busy,
            tbl[i].e_done, tbl[i].e_cnt);
    end
    drive(1'b0, 2'b00, 8'd0, 1'b0);
    tick;

    // Slow, bursts=1: 32 toggling ON cycles, 32 silent OFF cycles.
    drive(1'b1, 2'b01, 8'd1, 1'b0);
    tick;
    drive(1'b0, 2'b00, 8'd0, 1'b0);
    for (int c = 0; c < 64; c++) begin
      check($sformatf("slow1_c%0d", c), (c < 32) && (((c / 4) % 2) == 1),
            1'b1, 1'b0, 8'd0);
      tick;
    end
    check("slow1_done", 1'b0, 1'b0, 1'b1, 8'd1);
    tick;
    check("slow1_idle", 1'b0, 1'b0, 1'b0, 8'd1);

    // Continuous: 200 cycles of uninterrupted tone, then stop.
    drive(1'b1, 2'b11, 8'd0, 1'b0);
    tick;
    drive(1'b0, 2'b00, 8'd0, 1'b0);
    for (int c = 0; c < 200; c++) begin
      check($sformatf("cont_c%0d", c), ((c / 4) % 2) == 1, 1'b1, 1'b0, 8'd0);
      if (c == 199) stop = 1'b1;
      tick;
    end
    check("cont_stop", 1'b0, 1'b0, 1'b0, 8'd0);
    stop = 1'b0;
    tick;
    check("cont_no_done", 1'b0, 1'b0, 1'b0, 8'd0);

    // Fast, bursts=0: runs past 5 bursts; stop lands on the 6th OFF end.
    drive(1'b1, 2'b10, 8'd0, 1'b0);
    tick;
    drive(1'b0, 2'b00, 8'd0, 1'b0);
    for (int c = 0; c < 96; c++) begin
      check($sformatf("fast0_c%0d", c), ((c % 16) >= 4) && ((c % 16) < 8),
            1'b1, 1'b0, 8'(c / 16));
      if (c == 95) stop = 1'b1;
      tick;
    end
    check("fast0_stop", 1'b0, 1'b0, 1'b0, 8'd5);
    stop = 1'b0;
    tick;
    check("fast0_no_done", 1'b0, 1'b0, 1'b0, 8'd5);

    // Asynchronous reset mid-ON while the tone is high.
    drive(1'b1, 2'b10, 8'd2, 1'b0);
    tick;
    drive(1'b0, 2'b00, 8'd0, 1'b0);
    repeat (5) tick;
    check("pre_reset_on", 1'b1, 1'b1, 1'b0, 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check("post_reset_idle", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
